// File: rtl/sn74xx_pkg.sv
// Shared definitions for the clocked gate array: function codes, sequencer
// states and the supply qualification helper.
package sn74xx_pkg;

  localparam logic [2:0] MODE_NOR  = 3'd0;
  localparam logic [2:0] MODE_NAND = 3'd1;
  localparam logic [2:0] MODE_AND  = 3'd2;
  localparam logic [2:0] MODE_OR   = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_ON   = 2'd2
  } seq_state_e;

  // A floating or unknown pin is treated as no supply.
  function automatic logic supply_ok(input logic vcc, input logic gnd);
    return (vcc === 1'b1) && (gnd === 1'b0);
  endfunction

endpackage

// File: rtl/sn74xx_por_seq.sv
// Power-up sequencer: qualifies the supply pins, counts valid cycles and
// grants output updates once the ramp has completed.
module sn74xx_por_seq
  import sn74xx_pkg::*;
#(
  parameter int POR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic vcc,
  input  logic gnd,
  output logic upd_en,
  output logic power_good
);

  localparam int CW = (POR_CYCLES > 0) ? $clog2(POR_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          pg_q;
  logic          ok;

  assign ok         = supply_ok(vcc, gnd);
  // An edge in ON with a good supply is the only edge that moves y.
  assign upd_en     = (state_q == ST_ON) && ok;
  assign power_good = pg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      pg_q    <= 1'b0;
    end else begin
      pg_q <= upd_en;
      case (state_q)
        ST_OFF: begin
          cnt_q <= '0;
          if (ok) state_q <= (POR_CYCLES == 0) ? ST_ON : ST_RAMP;
        end
        ST_RAMP: begin
          if (!ok) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_ON;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ON: begin
          if (!ok) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_OFF;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sn74xx_gate_array.sv
// CHANNELS gates of INPUTS inputs each with a runtime-selected function;
// outputs are registered and only refreshed while the sequencer is ON.
module sn74xx_gate_array
  import sn74xx_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int INPUTS     = 2,
  parameter int POR_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vcc,
  input  logic                         gnd,
  input  logic [2:0]                   mode,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  output logic [CHANNELS-1:0]          y,
  output logic                         power_good
);

  logic                upd_en;
  logic [CHANNELS-1:0] y_d;
  logic [CHANNELS-1:0] y_q;

  sn74xx_por_seq #(.POR_CYCLES(POR_CYCLES)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .vcc        (vcc),
    .gnd        (gnd),
    .upd_en     (upd_en),
    .power_good (power_good)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [INPUTS-1:0] in_c;
    logic              f_c;

    assign in_c = a[c*INPUTS +: INPUTS];

    always_comb begin
      f_c = 1'b0;
      case (mode)
        MODE_NOR:  f_c = ~(|in_c);
        MODE_NAND: f_c = ~(&in_c);
        MODE_AND:  f_c = &in_c;
        MODE_OR:   f_c = |in_c;
        MODE_XOR:  f_c = ^in_c;
        MODE_XNOR: f_c = ~(^in_c);
        default:   f_c = 1'b0;
      endcase
    end

    assign y_d[c] = f_c;
  end

  always_ff @(posedge clk) begin
    if (rst)         y_q <= '0;
    else if (upd_en) y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: tb/tb_sn74xx_gate_array.sv
// Bench for sn74xx_gate_array: a default 4x2 array with an 8-cycle ramp and a
// 3x3 array with no ramp, both checked against a streak-counting model.
module tb_sn74xx_gate_array;

  localparam int POR0 = 8;
  localparam int POR1 = 0;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       vcc0 = 1'b1, gnd0 = 1'b0, vcc1 = 1'b1, gnd1 = 1'b0;
  logic [2:0] mode0 = '0, mode1 = '0;
  logic [7:0] a0 = '0;
  logic [8:0] a1 = '0;
  logic [3:0] y0;
  logic [2:0] y1;
  logic       pg0, pg1;

  int checks = 0;
  int failures = 0;

  sn74xx_gate_array #(.CHANNELS(4), .INPUTS(2), .POR_CYCLES(POR0)) u_dut0 (
    .clk(clk), .rst(rst), .vcc(vcc0), .gnd(gnd0), .mode(mode0), .a(a0),
    .y(y0), .power_good(pg0)
  );

  sn74xx_gate_array #(.CHANNELS(3), .INPUTS(3), .POR_CYCLES(POR1)) u_dut1 (
    .clk(clk), .rst(rst), .vcc(vcc1), .gnd(gnd1), .mode(mode1), .a(a1),
    .y(y1), .power_good(pg1)
  );

  // Gate function by counting ones among the first n bits.
  function automatic logic gate_ref(input logic [2:0] m, input logic [31:0] bits, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(bits[i]);
    case (m)
      3'd0:    return ones == 0;
      3'd1:    return ones != n;
      3'd2:    return ones == n;
      3'd3:    return ones > 0;
      3'd4:    return (ones % 2) == 1;
      3'd5:    return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Model: count consecutive good-supply edges; once POR+1 of them precede an
  // edge that is itself good, that edge refreshes y and raises power_good.
  int         streak0 = 0, streak1 = 0;
  logic [3:0] ey0 = '0;
  logic [2:0] ey1 = '0;
  logic       epg0 = 1'b0, epg1 = 1'b0;

  always @(posedge clk) begin : model
    logic ok0, ok1;
    ok0 = (vcc0 === 1'b1) && (gnd0 === 1'b0);
    ok1 = (vcc1 === 1'b1) && (gnd1 === 1'b0);
    if (rst) begin
      streak0 = 0; ey0 = '0; epg0 = 1'b0;
      streak1 = 0; ey1 = '0; epg1 = 1'b0;
    end else begin
      if (!ok0) begin
        streak0 = 0; epg0 = 1'b0;
      end else begin
        epg0 = (streak0 >= POR0 + 1);
        if (epg0) for (int c = 0; c < 4; c++) ey0[c] = gate_ref(mode0, 32'(a0) >> (2*c), 2);
        if (streak0 < 1000) streak0++;
      end
      if (!ok1) begin
        streak1 = 0; epg1 = 1'b0;
      end else begin
        epg1 = (streak1 >= POR1 + 1);
        if (epg1) for (int c = 0; c < 3; c++) ey1[c] = gate_ref(mode1, 32'(a1) >> (3*c), 3);
        if (streak1 < 1000) streak1++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks += 4;
    if (y0 !== 4'b0000) begin failures++; $display("FAIL reset_y0 got=%b exp=0000", y0); end
    if (pg0 !== 1'b0)   begin failures++; $display("FAIL reset_pg0 got=%b exp=0", pg0); end
    if (y1 !== 3'b000)  begin failures++; $display("FAIL reset_y1 got=%b exp=000", y1); end
    if (pg1 !== 1'b0)   begin failures++; $display("FAIL reset_pg1 got=%b exp=0", pg1); end
  endtask

  task automatic test_powerup();
    rst = 1'b0; mode0 = 3'd0; a0 = 8'h00;
    for (int i = 0; i <= POR0; i++) begin
      tick();
      checks += 2;
      if (pg0 !== 1'b0)   begin failures++; $display("FAIL powerup_pg_low edge=%0d got=%b exp=0", i, pg0); end
      if (y0 !== 4'b0000) begin failures++; $display("FAIL powerup_y_hold edge=%0d got=%b exp=0000", i, y0); end
    end
    tick();
    checks += 2;
    if (pg0 !== 1'b1)   begin failures++; $display("FAIL powerup_pg_rise got=%b exp=1", pg0); end
    if (y0 !== 4'b1111) begin failures++; $display("FAIL powerup_y_first got=%b exp=1111", y0); end
  endtask

  task automatic test_functions();
    mode0 = 3'd0; a0 = 8'b01_00_11_00;
    tick();
    checks++;
    if (y0 !== 4'b0101) begin failures++; $display("FAIL nor_pattern got=%b exp=0101", y0); end
    for (int m = 0; m < 8; m++) begin
      mode0 = 3'(m); a0 = 8'($urandom);
      tick();
      checks++;
      if (y0 !== ey0) begin failures++; $display("FAIL func_mode%0d a=%b got=%b exp=%b", m, a0, y0, ey0); end
    end
  endtask

  task automatic test_sweep();
    mode1 = 3'd5; a1 = 9'b111_011_001;
    tick();
    checks += 2;
    if (y1 !== 3'b010) begin failures++; $display("FAIL xnor_3x3 got=%b exp=010", y1); end
    if (pg1 !== 1'b1)  begin failures++; $display("FAIL xnor_3x3_pg got=%b exp=1", pg1); end
  endtask

  task automatic test_glitch();
    mode0 = 3'd3; a0 = 8'b11_00_01_00;
    tick();
    checks++;
    if (y0 !== 4'b1010) begin failures++; $display("FAIL glitch_setup got=%b exp=1010", y0); end
    gnd0 = 1'b1;
    tick();
    checks += 2;
    if (y0 !== 4'b1010) begin failures++; $display("FAIL glitch_hold got=%b exp=1010", y0); end
    if (pg0 !== 1'b0)   begin failures++; $display("FAIL glitch_pg got=%b exp=0", pg0); end
    gnd0 = 1'b0; a0 = 8'h00;
    for (int i = 0; i <= POR0; i++) begin
      tick();
      checks++;
      if (y0 !== 4'b1010 || pg0 !== 1'b0) begin
        failures++; $display("FAIL glitch_ramp edge=%0d got=%b/%b exp=1010/0", i, y0, pg0);
      end
    end
    tick();
    checks += 2;
    if (y0 !== 4'b0000) begin failures++; $display("FAIL glitch_resume got=%b exp=0000", y0); end
    if (pg0 !== 1'b1)   begin failures++; $display("FAIL glitch_resume_pg got=%b exp=1", pg0); end
  endtask

  task automatic test_rst_ramp();
    mode0 = 3'd3; a0 = 8'hff;
    tick();
    gnd0 = 1'b1;
    tick();
    gnd0 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (y0 !== 4'b1111 || pg0 !== 1'b0) begin
      failures++; $display("FAIL ramp_mid got=%b/%b exp=1111/0", y0, pg0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (y0 !== 4'b0000 || pg0 !== 1'b0) begin
      failures++; $display("FAIL ramp_rst got=%b/%b exp=0000/0", y0, pg0);
    end
    for (int i = 0; i <= POR0; i++) begin
      tick();
      checks++;
      if (pg0 !== 1'b0) begin failures++; $display("FAIL ramp_restart edge=%0d got=%b exp=0", i, pg0); end
    end
    tick();
    checks++;
    if (y0 !== 4'b1111 || pg0 !== 1'b1) begin
      failures++; $display("FAIL ramp_on got=%b/%b exp=1111/1", y0, pg0);
    end
  endtask

  task automatic test_por0();
    mode1 = 3'd0; a1 = 9'h000;
    tick();
    gnd1 = 1'b1;
    tick();
    gnd1 = 1'b0; mode1 = 3'd6; a1 = 9'($urandom);
    tick();
    checks++;
    if (pg1 !== 1'b0 || y1 !== 3'b111) begin
      failures++; $display("FAIL por0_enter got=%b/%b exp=111/0", y1, pg1);
    end
    a1 = 9'($urandom);
    tick();
    checks++;
    if (pg1 !== 1'b1 || y1 !== 3'b000) begin
      failures++; $display("FAIL por0_reserved got=%b/%b exp=000/1", y1, pg1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      mode0 = 3'(i % 8); a0 = 8'($urandom);
      mode1 = 3'((i + 3) % 8); a1 = 9'($urandom);
      tick();
      checks += 2;
      if (y0 !== ey0 || pg0 !== epg0) begin
        failures++; $display("FAIL b2b_dut0 i=%0d got=%b/%b exp=%b/%b", i, y0, pg0, ey0, epg0);
      end
      if (y1 !== ey1 || pg1 !== epg1) begin
        failures++; $display("FAIL b2b_dut1 i=%0d got=%b/%b exp=%b/%b", i, y1, pg1, ey1, epg1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      mode0 = 3'($urandom); a0 = 8'($urandom);
      mode1 = 3'($urandom); a1 = 9'($urandom);
      vcc0 = ($urandom_range(0, 59) != 0);
      gnd0 = ($urandom_range(0, 59) == 0);
      vcc1 = ($urandom_range(0, 9) != 0);
      gnd1 = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      tick();
      checks += 2;
      if (y0 !== ey0 || pg0 !== epg0) begin
        failures++; $display("FAIL rand_dut0 i=%0d got=%b/%b exp=%b/%b", i, y0, pg0, ey0, epg0);
      end
      if (y1 !== ey1 || pg1 !== epg1) begin
        failures++; $display("FAIL rand_dut1 i=%0d got=%b/%b exp=%b/%b", i, y1, pg1, ey1, epg1);
      end
    end
    rst = 1'b0; vcc0 = 1'b1; gnd0 = 1'b0; vcc1 = 1'b1; gnd1 = 1'b0;
    for (int i = 0; i < POR0 + 2; i++) tick();
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_functions();
    test_sweep();
    test_glitch();
    test_rst_ramp();
    test_por0();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
